// File: rtl/nibble_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides.
// A two-state FSM shifts one loaded word out bit by bit and can reload with no bubble cycle.
module nibble_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bitOut,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             xfer;

    // The register is cleared whenever the FSM goes idle, so its output bit reads 0 there.
    assign bitOut   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign in_ready = (state == IDLE) | (out_ready & out_last);
    assign load     = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= SHIFT;
                        shreg     <= dataIn;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (WIDTH == 1);
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (out_last) begin
                            if (in_valid) begin
                                shreg    <= dataIn;
                                cnt      <= '0;
                                out_last <= (WIDTH == 1);
                            end else begin
                                state     <= IDLE;
                                shreg     <= '0;
                                cnt       <= '0;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                busy      <= 1'b0;
                            end
                        end else begin
                            shreg    <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                            cnt      <= cnt + 1'b1;
                            // The next bit is the last one when the counter is about to reach WIDTH-1.
                            out_last <= (cnt == CW'(WIDTH - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serializer.sv
// Directed and random checks of nibble_serializer in both bit orders against a bit-queue model.
module tb_nibble_serializer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, iv, ordy;
    logic [W-1:0] din;
    logic         ir0, bo0, ov0, ol0, bz0;
    logic         ir1, bo1, ov1, ol1, bz1;

    int npass = 0, ntotal = 0;

    typedef struct {bit b; bit last;} ent_t;
    ent_t q0[$], q1[$];
    bit   log0[$], log1[$];

    always #5 clk = ~clk;

    nibble_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) d0 (
        .clk(clk), .reset(rst), .dataIn(din), .in_valid(iv), .in_ready(ir0),
        .bitOut(bo0), .out_valid(ov0), .out_ready(ordy), .out_last(ol0), .busy(bz0));
    nibble_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) d1 (
        .clk(clk), .reset(rst), .dataIn(din), .in_valid(iv), .in_ready(ir1),
        .bitOut(bo1), .out_valid(ov1), .out_ready(ordy), .out_last(ol1), .busy(bz1));

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pack(bit l[$]);
        logic [7:0] v = '0;
        foreach (l[i]) v = {v[6:0], l[i]};
        return v;
    endfunction

    bit hs; // load handshake taken at the last edge

    // Inputs are set at the falling edge; check just after, then advance the model at the rising edge.
    task automatic cycle(string tag);
        bit e_ir0, e_ir1;
        #1;
        e_ir0 = (q0.size() == 0) || (ordy && q0[0].last);
        e_ir1 = (q1.size() == 0) || (ordy && q1[0].last);
        chk({tag, ".ov0"}, ov0, q0.size() > 0);
        chk({tag, ".bz0"}, bz0, q0.size() > 0);
        chk({tag, ".bo0"}, bo0, q0.size() > 0 ? q0[0].b : 1'b0);
        chk({tag, ".ol0"}, ol0, q0.size() > 0 ? q0[0].last : 1'b0);
        chk({tag, ".ir0"}, ir0, e_ir0);
        chk({tag, ".ov1"}, ov1, q1.size() > 0);
        chk({tag, ".bz1"}, bz1, q1.size() > 0);
        chk({tag, ".bo1"}, bo1, q1.size() > 0 ? q1[0].b : 1'b0);
        chk({tag, ".ol1"}, ol1, q1.size() > 0 ? q1[0].last : 1'b0);
        chk({tag, ".ir1"}, ir1, e_ir1);
        if (!rst && ov0 && ordy) log0.push_back(bo0);
        if (!rst && ov1 && ordy) log1.push_back(bo1);
        @(posedge clk);
        hs = 1'b0;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() > 0 && ordy) void'(q0.pop_front());
            if (q1.size() > 0 && ordy) void'(q1.pop_front());
            if (iv && e_ir0) begin
                hs = 1'b1;
                for (int i = 0; i < W; i++) begin
                    q0.push_back('{b: din[i], last: (i == W - 1)});
                    q1.push_back('{b: din[W-1-i], last: (i == W - 1)});
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; din = '0;
        @(negedge clk);
        cycle("rst_a");
        cycle("rst_b");
        rst = 1'b0;
        cycle("idle");

        // 1011: LSB-first 1,1,0,1 and MSB-first 1,0,1,1
        log0.delete(); log1.delete();
        din = 4'b1011; iv = 1'b1; ordy = 1'b1;
        cycle("w1011_ld");
        iv = 1'b0;
        repeat (5) cycle("w1011");
        chk("seq1011_lsb", pack(log0), 8'b1101);
        chk("seq1011_msb", pack(log1), 8'b1011);

        // 0110 with out_ready dropped for three cycles after the second bit
        log0.delete(); log1.delete();
        din = 4'b0110; iv = 1'b1;
        cycle("w0110_ld");
        iv = 1'b0;
        repeat (2) cycle("w0110_a");
        ordy = 1'b0;
        repeat (3) cycle("w0110_stall");
        ordy = 1'b1;
        repeat (3) cycle("w0110_b");
        chk("seq0110_lsb", pack(log0), 8'b0110);
        chk("seq0110_len", log0.size(), 4);

        // back-to-back A then 5
        log0.delete(); log1.delete();
        din = 4'hA; iv = 1'b1;
        cycle("b2b_ldA");
        din = 4'h5;
        repeat (4) cycle("b2b_A");
        iv = 1'b0;
        repeat (5) cycle("b2b_5");
        chk("seq_b2b_lsb", pack(log0), 8'b01011010);
        chk("seq_b2b_msb", pack(log1), 8'b10100101);

        // reset mid-word, with a simultaneous load attempt
        din = 4'h9; iv = 1'b1;
        cycle("rstmid_ld");
        iv = 1'b0;
        repeat (2) cycle("rstmid_sh");
        rst = 1'b1; iv = 1'b1; din = 4'h6;
        cycle("rstmid_rst");
        rst = 1'b0; iv = 1'b0;
        cycle("rstmid_after");
        log0.delete(); log1.delete();
        din = 4'hF; iv = 1'b1;
        cycle("rstmid_ldF");
        iv = 1'b0;
        repeat (5) cycle("rstmid_F");
        chk("seqF_lsb", pack(log0), 8'b1111);

        // word offered while busy is ignored
        log0.delete(); log1.delete();
        din = 4'hC; iv = 1'b1;
        cycle("ign_ldC");
        din = 4'h3;
        repeat (2) cycle("ign_pulse");
        iv = 1'b0;
        repeat (3) cycle("ign_C");
        chk("seqC_lsb", pack(log0), 8'b0011);
        chk("seqC_len", log0.size(), 4);

        // random traffic; producer holds a word until it is taken
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            if (!iv || hs) begin
                iv  = ($urandom_range(0, 2) != 0);
                din = W'($urandom);
            end
            cycle("rand");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/nibble_serializer.md
NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter WIDTH, default 4, number of data bits per word loaded and shifted out.
REQ-002 Parameter MSB_FIRST, default 0; 0 = bit 0 sent first, 1 = bit WIDTH-1 sent first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 dataIn  input  WIDTH  parallel word to serialize, sampled when in_valid & in_ready.
REQ-006 in_valid  input  1  producer asserts when dataIn holds a word.
REQ-007 in_ready  output  1  serializer can accept a word this cycle.
REQ-008 bitOut  output  1  current serial bit.
REQ-009 out_valid  output  1  bitOut is valid.
REQ-010 out_ready  input  1  consumer accepts bitOut this cycle.
REQ-011 out_last  output  1  bitOut is the final bit of the current word.
REQ-012 busy  output  1  a word is loaded and not yet fully accepted.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 IDLE: in_ready=1, out_valid=0, busy=0; bitOut and out_last SHALL be 0.
REQ-015 IDLE -> SHIFT on in_valid & in_ready: capture dataIn into shift register, bit counter cleared to 0.
REQ-016 SHIFT: out_valid=1, busy=1; bitOut = shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
REQ-017 Latency: first bit SHALL appear on bitOut, with out_valid=1, the cycle after the load handshake.
REQ-018 A bit transfer occurs only on out_valid & out_ready; on transfer the shift register SHALL shift one position toward the output end and the counter SHALL increment.
REQ-019 With out_ready=0 in SHIFT, bitOut, out_last, shift register and counter SHALL hold unchanged (no bit lost or repeated).
REQ-020 out_last SHALL be 1 exactly when the counter equals WIDTH-1 in SHIFT.
REQ-021 in_ready in SHIFT SHALL equal out_ready & out_last (zero-bubble reload).
REQ-022 On final transfer (out_valid & out_ready & out_last): with in_valid=1, load new word and stay in SHIFT with counter 0; with in_valid=0, go to IDLE.
REQ-023 in_valid while in_ready=0 SHALL be ignored; the producer holds dataIn/in_valid until handshake.
REQ-024 Counter width SHALL be $clog2(WIDTH) bits minimum; no wrap past WIDTH-1 inside one word.
REQ-025 Words SHALL be sent in acceptance order with no gap cycles when producer and consumer are both always ready.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, clear shift register and counter, regardless of state, including mid-word.
REQ-027 After reset: in_ready=1, out_valid=0, out_last=0, bitOut=0, busy=0; a partially sent word is discarded.
REQ-028 reset SHALL take priority over simultaneous load or transfer handshakes in the same cycle.

Verification
REQ-029 Reset, then load 4'b1011, out_ready=1, MSB_FIRST=0 -> bitOut sequence 1,1,0,1 on cycles 1-4 after load, out_last only on cycle 4, then IDLE.
REQ-030 Same word with MSB_FIRST=1 -> sequence 1,0,1,1; out_last on 4th bit.
REQ-031 Load 4'b0110, drop out_ready for 3 cycles after 2nd bit -> bitOut holds 1 (3rd bit) steady, out_valid=1, then sequence completes 0,1,1,0 with no duplicates.
REQ-032 Back-to-back words 4'hA then 4'h5 with in_valid held, out_ready=1 -> 8 consecutive valid bits 0,1,0,1,1,0,1,0, in_ready pulses only with 1st load and on 4th bit of 4'hA.
REQ-033 Assert reset while 3rd bit pending -> next cycle out_valid=0, in_ready=1, busy=0; fresh load of 4'hF then emits 1,1,1,1.
REQ-034 in_valid pulsed with 4'h3 while busy with in_ready=0 -> word ignored, current word output unaffected.
